mul_div_unit: RTL

- Multi-cycle integer multiply/divide unit with architectural HI/LO registers for the MIPS-style datapath.
- Replaces the single-cycle combinational multiply path inside the ALU.
- Iterative (one bit per cycle) engine with a start/busy/done handshake. Supports signed and unsigned MULT/DIV plus direct HI/LO writes (MTHI/MTLO).
- HI/LO are always visible on outputs; the datapath result mux implements MFHI/MFLO.

---
 rtl/mul_div_unit_if.sv | 23 ++
 rtl/mul_div_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the datapath and the multiply/divide unit.
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One multiply (shift-add) or restoring divide bit per cycle, then a sign fixup cycle.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  mul_div_unit_if.slave io_bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFixup, StDone} state_e;

  state_e               r_state, w_state_next;
  logic [CntW-1:0]      r_cnt, w_cnt_next;
  // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0]   r_acc, w_acc_next;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]     r_opnd, w_opnd_next;
  logic [WIDTH-1:0]     r_hi, w_hi_next;
  logic [WIDTH-1:0]     r_lo, w_lo_next;
  logic                 r_sign_a, w_sign_a_next;
  logic                 r_sign_b, w_sign_b_next;
  logic                 r_is_div, w_is_div_next;
  logic                 r_signed, w_signed_next;
  logic                 r_div0, w_div0_next;

  logic                 w_a_neg, w_b_neg;
  logic [WIDTH-1:0]     w_a_mag, w_b_mag;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_step;
  logic [WIDTH:0]       w_shift, w_diff;
  logic                 w_ge;
  logic [2*WIDTH-1:0]   w_div_step;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quo_fix, w_rem_fix;

  // Operand magnitudes and single-step datapath for both engines.
  always_comb begin
    w_a_neg    = io_bus.op[0] & io_bus.a[WIDTH-1];
    w_b_neg    = io_bus.op[0] & io_bus.b[WIDTH-1];
    w_a_mag    = w_a_neg ? -io_bus.a : io_bus.a;
    w_b_mag    = w_b_neg ? -io_bus.b : io_bus.b;

    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

    w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_ge       = (w_shift >= {1'b0, r_opnd});
    w_diff     = w_shift - {1'b0, r_opnd};
    w_div_step = {(w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

    w_prod_fix = (r_signed && (r_sign_a ^ r_sign_b)) ? -r_acc : r_acc;
    // Divide by zero: quotient all ones; remainder recovers the original dividend.
    w_quo_fix  = r_div0 ? '1 :
                 ((r_signed && (r_sign_a ^ r_sign_b)) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    w_rem_fix  = (r_signed && r_sign_a) ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  end

  // Next-state, operand capture and HI/LO update.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_acc_next    = r_acc;
    w_opnd_next   = r_opnd;
    w_hi_next     = r_hi;
    w_lo_next     = r_lo;
    w_sign_a_next = r_sign_a;
    w_sign_b_next = r_sign_b;
    w_is_div_next = r_is_div;
    w_signed_next = r_signed;
    w_div0_next   = r_div0;

    unique case (r_state)
      StIdle, StDone: begin
        w_state_next = StIdle;
        if (io_bus.start) begin
          if (!io_bus.op[2]) begin
            w_acc_next    = io_bus.op[1] ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
            w_opnd_next   = io_bus.op[1] ? w_b_mag : w_a_mag;
            w_sign_a_next = w_a_neg;
            w_sign_b_next = w_b_neg;
            w_is_div_next = io_bus.op[1];
            w_signed_next = io_bus.op[0];
            w_div0_next   = (io_bus.b == '0);
            w_cnt_next    = CntW'(WIDTH);
            w_state_next  = StRun;
          end else if (io_bus.op[1:0] == 2'b00) begin
            w_hi_next = io_bus.a;
          end else if (io_bus.op[1:0] == 2'b01) begin
            w_lo_next = io_bus.a;
          end
        end
      end
      StRun: begin
        w_acc_next = r_is_div ? w_div_step : w_mul_step;
        w_cnt_next = r_cnt - CntW'(1);
        if (r_cnt == CntW'(1)) begin
          w_state_next = StFixup;
        end
      end
      StFixup: begin
        if (r_is_div) begin
          w_hi_next = w_rem_fix;
          w_lo_next = w_quo_fix;
        end else begin
          w_hi_next = w_prod_fix[2*WIDTH-1:WIDTH];
          w_lo_next = w_prod_fix[WIDTH-1:0];
        end
        w_state_next = StDone;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_is_div <= 1'b0;
      r_signed <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_acc    <= w_acc_next;
      r_opnd   <= w_opnd_next;
      r_hi     <= w_hi_next;
      r_lo     <= w_lo_next;
      r_sign_a <= w_sign_a_next;
      r_sign_b <= w_sign_b_next;
      r_is_div <= w_is_div_next;
      r_signed <= w_signed_next;
      r_div0   <= w_div0_next;
    end
  end

  assign io_bus.busy = (r_state == StRun) || (r_state == StFixup);
  assign io_bus.done = (r_state == StDone);
  assign io_bus.hi   = r_hi;
  assign io_bus.lo   = r_lo;

endmodule
